// File: rtl/win3x3_gen_pkg.sv
// rtl/win3x3_gen_pkg.sv - shared window constants and latency; WIN3X3_OUT_REG_EN selects L=3
`ifdef WIN3X3_OUT_REG_EN
`define WIN3X3_LAT 3
`else
`define WIN3X3_LAT 2
`endif

package win3x3_gen_pkg;
    localparam int KSZ  = 3;
    localparam int NTAP = KSZ * KSZ;

    // Tap slot within dout_win, counted from the LSB in units of DW
    localparam int P11 = 8;
    localparam int P12 = 7;
    localparam int P13 = 6;
    localparam int P21 = 5;
    localparam int P22 = 4;
    localparam int P23 = 3;
    localparam int P31 = 2;
    localparam int P32 = 1;
    localparam int P33 = 0;

    // Cycles from the newest pixel on din to its window on dout_win
    localparam int LAT = `WIN3X3_LAT;
endpackage

// File: rtl/win3x3_gen_if.sv
// rtl/win3x3_gen_if.sv - padded raster in / 3x3 window out bundle
interface win3x3_gen_if #(
    parameter int DW = 8
);
    logic            din_vsync;
    logic            din_hsync;
    logic [DW-1:0]   din;
    logic            dout_vsync;
    logic            dout_hsync;
    logic [9*DW-1:0] dout_win;

    modport master (
        output din_vsync, din_hsync, din,
        input  dout_vsync, dout_hsync, dout_win
    );

    modport slave (
        input  din_vsync, din_hsync, din,
        output dout_vsync, dout_hsync, dout_win
    );
endinterface

// File: rtl/win3x3_gen_linebuf.sv
// rtl/win3x3_gen_linebuf.sv - simple dual-port line RAM, registered read-before-write
module win3x3_linebuf
    import win3x3_gen_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic          rd_en_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [DW-1:0] rd_data_o
);
    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rd_data_q;

    // Storage array; left without reset so it can map onto block RAM
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Registered read; a same-address write in the same cycle returns the old word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;
endmodule

// File: rtl/win3x3_gen.sv
// rtl/win3x3_gen.sv - 3x3 window generator for padded raster; WIN3X3_OUT_REG_EN adds output stage
module win3x3_gen
    import win3x3_gen_pkg::*;
#(
    parameter int DW    = 8,
    parameter int IW    = 4,
    parameter int IH    = 2,
    parameter int LB_AW = 4
) (
    input  logic         clk,
    input  logic         rst,
    win3x3_gen_if.slave  bus
);
    localparam int LW = IW + 2;
    localparam int CW = LB_AW + 1;
    localparam int RW = $clog2(IH + 2) + 1;
    localparam int WW = NTAP * DW;
    localparam logic [CW-1:0] LW_C    = CW'(LW);
    localparam logic [CW-1:0] COL_MAX = '1;
    localparam logic [RW-1:0] ROW_MAX = '1;

    logic             vs_prev_q, hs_prev_q, armed_q;
    logic             armed_d;
    logic [CW-1:0]    col_q, col_d;
    logic [RW-1:0]    row_q, row_d;

    logic             vs_rise, hs_fall, armed_now, pix, in_line, win_now;
    logic [CW-1:0]    cur_col;
    logic [RW-1:0]    cur_row;

    logic             s1_wr_q, s1_win_q;
    logic [LB_AW-1:0] s1_addr_q;
    logic [DW-1:0]    s1_din_q;

    logic [DW-1:0]    lb0_rd, lb1_rd;
    logic [DW-1:0]    win_q [KSZ][KSZ];
    logic [DW-1:0]    col_new [KSZ];
    logic [WW-1:0]    win_flat;
    logic             hs2_q, vs1_q, vs2_q;

    // Frame arming and position of the pixel currently on din
    always_comb begin
        vs_rise   = bus.din_vsync & ~vs_prev_q;
        hs_fall   = hs_prev_q & ~bus.din_hsync;
        armed_now = bus.din_vsync & (armed_q | vs_rise);
        cur_col   = vs_rise ? '0 : col_q;
        cur_row   = vs_rise ? '0 : row_q;
        pix       = armed_now & bus.din_hsync;
        in_line   = pix & (cur_col < LW_C);
        win_now   = in_line & (cur_row >= RW'(2)) & (cur_col >= CW'(2));
    end

    // Next-state for the saturating column/row counters and arm flag
    always_comb begin
        armed_d = armed_now;
        col_d   = col_q;
        row_d   = row_q;
        if (!bus.din_vsync) begin
            col_d = '0;
        end else if (vs_rise) begin
            col_d = pix ? CW'(1) : '0;
            row_d = '0;
        end else if (armed_q) begin
            if (pix) begin
                col_d = (col_q == COL_MAX) ? col_q : col_q + CW'(1);
            end else if (hs_fall) begin
                col_d = '0;
                row_d = (row_q == ROW_MAX) ? row_q : row_q + RW'(1);
            end
        end
    end

    // Control state; vs_prev resets high so a frame already in progress at reset is not re-armed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_prev_q <= 1'b1;
            hs_prev_q <= 1'b0;
            armed_q   <= 1'b0;
            col_q     <= '0;
            row_q     <= '0;
        end else begin
            vs_prev_q <= bus.din_vsync;
            hs_prev_q <= bus.din_hsync;
            armed_q   <= armed_d;
            col_q     <= col_d;
            row_q     <= row_d;
        end
    end

    // Stage 1: hold the pixel while both line buffers return their old column words
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_wr_q   <= 1'b0;
            s1_win_q  <= 1'b0;
            s1_addr_q <= '0;
            s1_din_q  <= '0;
        end else begin
            s1_wr_q   <= in_line;
            s1_win_q  <= win_now;
            s1_addr_q <= cur_col[LB_AW-1:0];
            s1_din_q  <= bus.din;
        end
    end

    // lb0 holds row-1; lb1 is fed lb0's old word one cycle later and holds row-2
    win3x3_linebuf #(.DW(DW), .AW(LB_AW)) u_lb0 (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (in_line),
        .wr_addr_i (cur_col[LB_AW-1:0]),
        .wr_data_i (bus.din),
        .rd_en_i   (in_line),
        .rd_addr_i (cur_col[LB_AW-1:0]),
        .rd_data_o (lb0_rd)
    );

    win3x3_linebuf #(.DW(DW), .AW(LB_AW)) u_lb1 (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (s1_wr_q),
        .wr_addr_i (s1_addr_q),
        .wr_data_i (lb0_rd),
        .rd_en_i   (in_line),
        .rd_addr_i (cur_col[LB_AW-1:0]),
        .rd_data_o (lb1_rd)
    );

    // New window column, top (oldest row) to bottom (current row)
    always_comb begin
        col_new[0] = lb1_rd;
        col_new[1] = lb0_rd;
        col_new[2] = s1_din_q;
    end

    // Column shift array: moves left one column per accepted pixel, holds otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < KSZ; r++) begin
                for (int c = 0; c < KSZ; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else if (s1_wr_q) begin
            for (int r = 0; r < KSZ; r++) begin
                win_q[r][0] <= win_q[r][1];
                win_q[r][1] <= win_q[r][2];
                win_q[r][2] <= col_new[r];
            end
        end
    end

    // Flatten with p11 in the top slot and p33 in the bottom slot
    always_comb begin
        win_flat = '0;
        for (int r = 0; r < KSZ; r++) begin
            for (int c = 0; c < KSZ; c++) begin
                win_flat[(NTAP - 1 - (r * KSZ + c)) * DW +: DW] = win_q[r][c];
            end
        end
    end

    // Sync delay lines aligned with the window array
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs2_q <= 1'b0;
            vs1_q <= 1'b0;
            vs2_q <= 1'b0;
        end else begin
            hs2_q <= s1_win_q;
            vs1_q <= bus.din_vsync;
            vs2_q <= vs1_q;
        end
    end

`ifdef WIN3X3_OUT_REG_EN
    logic          out_vs_q, out_hs_q;
    logic [WW-1:0] out_win_q;

    // Extra output stage adding one cycle to every output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vs_q  <= 1'b0;
            out_hs_q  <= 1'b0;
            out_win_q <= '0;
        end else begin
            out_vs_q  <= vs2_q;
            out_hs_q  <= hs2_q;
            out_win_q <= win_flat;
        end
    end

    assign bus.dout_vsync = out_vs_q;
    assign bus.dout_hsync = out_hs_q;
    assign bus.dout_win   = out_win_q;
`else
    assign bus.dout_vsync = vs2_q;
    assign bus.dout_hsync = hs2_q;
    assign bus.dout_win   = win_flat;
`endif
endmodule

// File: tb/tb_win3x3_gen.sv
// tb/tb_win3x3_gen.sv - scoreboard bench for win3x3_gen; latency follows WIN3X3_OUT_REG_EN
module tb_win3x3_gen;
    import win3x3_gen_pkg::*;

    localparam int DW    = 8;
    localparam int IW    = 4;
    localparam int IH    = 2;
    localparam int LB_AW = 4;
    localparam int LW    = IW + 2;
    localparam int WW    = NTAP * DW;
    localparam logic [WW-1:0] FIRST_WIN = 72'h00_01_02_0A_0B_0C_14_15_16;
    localparam logic [WW-1:0] LAST_WIN  = 72'h0D_0E_0F_17_18_19_21_22_23;

    typedef struct {
        logic [WW-1:0] win;
        int            cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    win3x3_gen_if #(.DW(DW)) bus ();

    win3x3_gen #(.DW(DW), .IW(IW), .IH(IH), .LB_AW(LB_AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int            checks   = 0;
    int            failures = 0;
    int            cyc      = 0;
    int            win_cnt  = 0;
    bit            chk_vs   = 1'b0;
    bit            saw99    = 1'b0;
    logic [7:0]    vs_sr    = '0;
    logic [WW-1:0] first_win = '0;
    logic [WW-1:0] last_win  = '0;
    exp_t          exp_q[$];
    exp_t          mon_e;

    task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WW-1:0] win_of(input int r, input int c);
        logic [WW-1:0] w = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                w = {w[WW-DW-1:0], 8'(10 * (r - 2 + i) + (c - 2 + j))};
            end
        end
        return w;
    endfunction

    task automatic chk_reset_outputs();
        chk("rst_dout_vsync", WW'(bus.dout_vsync), '0);
        chk("rst_dout_hsync", WW'(bus.dout_hsync), '0);
        chk("rst_dout_win", bus.dout_win, '0);
    endtask

    // rst_row: row in which reset is pulsed (-1 none); long_row: row driven 8 pixels (-1 none)
    task automatic run_frame(input int rst_row, input int long_row, input int gap);
        bit   exp_on = 1'b1;
        exp_t e;
        win_cnt = 0;
        bus.din_vsync = 1'b1;
        step();
        step();
        for (int r = 0; r < 4; r++) begin
            int len = (r == long_row) ? 8 : LW;
            for (int c = 0; c < len; c++) begin
                if (r == rst_row && c == 3) begin
                    bus.din_hsync = 1'b0;
                    rst = 1'b1;
                    #2;
                    chk_reset_outputs();
                    step();
                    step();
                    rst = 1'b0;
                    exp_on = 1'b0;
                end
                bus.din_hsync = 1'b1;
                bus.din = (c >= LW) ? 8'd99 : 8'(10 * r + c);
                if (exp_on && r >= 2 && c >= 2 && c < LW) begin
                    e.win = win_of(r, c);
                    e.cyc = cyc + LAT;
                    exp_q.push_back(e);
                end
                step();
            end
            bus.din_hsync = 1'b0;
            step();
        end
        step();
        bus.din_vsync = 1'b0;
        repeat (gap) step();
    endtask

    // Cycle counter and din_vsync history sampled at each active edge
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        vs_sr <= {vs_sr[6:0], bus.din_vsync};
    end

    // Monitor: pops the scoreboard whenever a window is presented
    always @(negedge clk) begin
        if (!rst) begin
            if (chk_vs) begin
                chk("dout_vsync_delay", WW'(bus.dout_vsync), WW'(vs_sr[LAT-1]));
            end
            if (bus.dout_hsync === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_window actual=%0h required=none", bus.dout_win);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("window", bus.dout_win, mon_e.win);
                    chk("window_cycle", WW'(cyc), WW'(mon_e.cyc));
                end
                if (win_cnt == 0) first_win = bus.dout_win;
                last_win = bus.dout_win;
                win_cnt++;
                for (int t = 0; t < NTAP; t++) begin
                    if (bus.dout_win[t*DW +: DW] == 8'd99) saw99 = 1'b1;
                end
            end
        end
    end

    task automatic chk_frame(input string tag, input int nwin);
        chk({tag, "_win_count"}, WW'(win_cnt), WW'(nwin));
        chk({tag, "_queue_drained"}, WW'(exp_q.size()), '0);
        if (nwin > 0) begin
            chk({tag, "_first_win"}, first_win, FIRST_WIN);
            chk({tag, "_last_win"}, last_win, LAST_WIN);
        end
    endtask

    initial begin
        bus.din_vsync = 1'b0;
        bus.din_hsync = 1'b0;
        bus.din       = '0;
        rst = 1'b1;
        step();
        step();
        chk_reset_outputs();
        rst = 1'b0;
        step();

        // Single frame: first/last window, count, latency and vsync delay
        chk_vs = 1'b1;
        run_frame(-1, -1, 28);
        chk_vs = 1'b0;
        chk_frame("frame1", 8);

        // Reset during row 1: rest of that frame discarded
        run_frame(1, -1, 28);
        chk_frame("rst_frame", 0);

        // Following frame reproduces the single-frame result
        run_frame(-1, -1, 28);
        chk_frame("after_rst", 8);

        // Overlong row 3 with trailing 99s
        saw99 = 1'b0;
        run_frame(-1, 3, 28);
        chk_frame("long_row", 8);
        chk("no_99_in_window", WW'(saw99), '0);

        // Back-to-back frames, 28-cycle vsync gap, vsync delay checked throughout
        chk_vs = 1'b1;
        run_frame(-1, -1, 28);
        chk_frame("b2b_a", 8);
        run_frame(-1, -1, 28);
        chk_frame("b2b_b", 8);
        chk_vs = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
